// File: rtl/logic_unit_if.sv
// logic_unit_if: operand/result handshake bundle for logic_unit_pipe.
interface logic_unit_if #(parameter int N = 32);
  logic         IN_VALID;
  logic         IN_READY;
  logic [1:0]   OP;
  logic [N-1:0] IN1;
  logic [N-1:0] IN2;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [N-1:0] RES;
  logic         ZERO;
  logic         BUSY;
  modport master (
    output IN_VALID, OP, IN1, IN2, OUT_READY,
    input  IN_READY, OUT_VALID, RES, ZERO, BUSY
  );
  modport slave (
    input  IN_VALID, OP, IN1, IN2, OUT_READY,
    output IN_READY, OUT_VALID, RES, ZERO, BUSY
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: AND/OR/XOR/XNOR unit feeding a bubble-collapsing valid/ready pipeline.
module logic_unit_pipe #(
  parameter int N      = 32,
  parameter int STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  logic_unit_if.slave bus
);
  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_zero;
  logic [N-1:0]      r_data [STAGES];
  logic [STAGES-1:0] w_rdy;
  logic [N-1:0]      w_res;
  always_comb
    w_res = bus.OP == 2'b00 ? bus.IN1 & bus.IN2 :
            bus.OP == 2'b01 ? bus.IN1 | bus.IN2 :
            bus.OP == 2'b10 ? bus.IN1 ^ bus.IN2 : ~(bus.IN1 ^ bus.IN2);
  // A stage is ready when empty or when everything ahead of it drains this cycle.
  always_comb begin : ready_chain
    logic w_c;
    w_c   = bus.OUT_READY;
    w_rdy = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_rdy[k] = !r_valid[k] || w_c;
      w_c      = w_rdy[k];
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid <= '0;
      r_zero  <= '0;
      for (int k = 0; k < STAGES; k++) r_data[k] <= '0;
    end else begin
      if (w_rdy[0]) begin
        r_valid[0] <= bus.IN_VALID;
        r_data[0]  <= w_res;
        r_zero[0]  <= w_res == '0;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_rdy[k]) begin
          r_valid[k] <= r_valid[k-1];
          r_data[k]  <= r_data[k-1];
          r_zero[k]  <= r_zero[k-1];
        end
      end
    end
  end
  assign bus.IN_READY  = w_rdy[0];
  assign bus.OUT_VALID = r_valid[STAGES-1];
  assign bus.RES       = r_data[STAGES-1];
  assign bus.ZERO      = r_zero[STAGES-1];
  assign bus.BUSY      = |r_valid;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed + random checks of STAGES=2 and STAGES=3 instances against a queue model.
module tb_logic_unit_pipe;
  localparam int N = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv = 1'b0;
  logic ordy = 1'b0;
  logic [1:0] op = '0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  logic_unit_if #(.N(N)) b2 ();
  logic_unit_if #(.N(N)) b3 ();
  assign b2.IN_VALID = iv;  assign b3.IN_VALID = iv;
  assign b2.OUT_READY = ordy; assign b3.OUT_READY = ordy;
  assign b2.OP = op;  assign b3.OP = op;
  assign b2.IN1 = a;  assign b3.IN1 = a;
  assign b2.IN2 = b;  assign b3.IN2 = b;
  logic_unit_pipe #(.N(N), .STAGES(2)) u2 (.CLK(clk), .RST(rst), .bus(b2.slave));
  logic_unit_pipe #(.N(N), .STAGES(3)) u3 (.CLK(clk), .RST(rst), .bus(b3.slave));
  int S [2] = '{2, 3};
  int cnt [2] = '{0, 0};
  int hd [2] = '{0, 0};
  int lastpop [2] = '{-1, -1};
  int pushes [2] = '{0, 0};
  int acc_t [2][8];
  logic [N-1:0] md [2][8];
  logic post_rst = 1'b0;
  logic [N-1:0] got0 [$];
  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [N-1:0] f(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      case (o)
        2'd0: r[i] = x[i] && y[i];
        2'd1: r[i] = x[i] || y[i];
        2'd2: r[i] = x[i] != y[i];
        default: r[i] = x[i] == y[i];
      endcase
    return r;
  endfunction
  task automatic tick();
    logic ir, ov, z, bz, ev, er;
    logic [N-1:0] rs;
    int slot;
    #3;
    for (int d = 0; d < 2; d++) begin
      ir = d == 0 ? b2.IN_READY : b3.IN_READY;
      ov = d == 0 ? b2.OUT_VALID : b3.OUT_VALID;
      rs = d == 0 ? b2.RES : b3.RES;
      z  = d == 0 ? b2.ZERO : b3.ZERO;
      bz = d == 0 ? b2.BUSY : b3.BUSY;
      er = cnt[d] < S[d] || ordy;
      ev = cnt[d] > 0 && cyc >= acc_t[d][hd[d]] + S[d] && cyc > lastpop[d];
      chk("in_ready", ir, er);
      chk("out_valid", ov, ev);
      chk("busy", bz, cnt[d] > 0);
      if (post_rst) begin
        chk("rst_res", rs, {N{1'b0}});
        chk("rst_zero", z, 1'b0);
      end
      if (ev) begin
        chk("res", rs, md[d][hd[d]]);
        chk("zero", z, md[d][hd[d]] == '0);
      end
      if (rst) begin
        cnt[d] = 0;
        hd[d] = 0;
        lastpop[d] = -1;
      end else begin
        if (ev && ordy) begin
          if (d == 0) got0.push_back(rs);
          hd[d] = (hd[d] + 1) % 8;
          cnt[d]--;
          lastpop[d] = cyc;
        end
        if (iv && er) begin
          slot = (hd[d] + cnt[d]) % 8;
          md[d][slot] = f(op, a, b);
          acc_t[d][slot] = cyc;
          cnt[d]++;
          pushes[d]++;
        end
      end
    end
    post_rst = rst;
    cyc++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [N-1:0] exp_ops [6];
    exp_ops[0] = 32'hF000_000F; exp_ops[1] = 32'hFFF0_0FFF;
    exp_ops[2] = 32'h0FF0_0FF0; exp_ops[3] = 32'hF00F_F00F;
    exp_ops[4] = 32'h0; exp_ops[5] = 32'h0;
    @(posedge clk);
    #1;
    rst = 1; iv = 1; a = 32'h1234_5678; b = 32'h0F0F_0F0F;
    tick(); tick();
    rst = 0; iv = 0;
    repeat (4) tick();
    ordy = 1; iv = 1; a = 32'hF0F0_00FF; b = 32'hFF00_0F0F;
    got0.delete();
    for (int i = 0; i < 4; i++) begin op = 2'(i); tick(); end
    op = 2'd2; a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF; tick();
    op = 2'd3; a = 32'h0; b = 32'hFFFF_FFFF; tick();
    iv = 0;
    repeat (5) tick();
    chk("ops_count", got0.size(), 6);
    for (int i = 0; i < 6 && i < got0.size(); i++) chk("ops_res", got0[i], exp_ops[i]);
    ordy = 0; iv = 1; pushes[0] = 0; pushes[1] = 0;
    for (int i = 0; i < 5; i++) begin a = $urandom; b = $urandom; op = 2'($urandom); tick(); end
    chk("bp_accepted2", pushes[0], 2);
    chk("bp_accepted3", pushes[1], 3);
    iv = 0; ordy = 1;
    repeat (5) tick();
    chk("bp_drained", cnt[0] + cnt[1], 0);
    ordy = 0; iv = 1;
    repeat (3) begin a = $urandom; b = $urandom; tick(); end
    rst = 1; tick();
    rst = 0; iv = 0; ordy = 1;
    repeat (6) tick();
    for (int i = 0; i < 400; i++) begin
      iv = ($urandom % 4) != 0;
      ordy = ($urandom % 3) != 0;
      rst = ($urandom % 64) == 0;
      op = 2'($urandom);
      a = $urandom;
      b = ($urandom % 5) == 0 ? ((op == 2'd3) ? ~a : a) : $urandom;
      tick();
    end
    rst = 0; iv = 0; ordy = 1;
    repeat (6) tick();
    chk("final_empty", cnt[0] + cnt[1], 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
